des_round_ctrl: RTL and testbench



---
 rtl/des_round_ctrl.sv | 159 +++++++++++++++
 tb/tb_des_round_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// Iterative DES round controller: L/R and C/D state plus 16-round sequencing with valid/ready on both sides.
// Optional macro DES_ROUND_CTRL_DECRYPT_EN builds the decrypt (right-rotate) key path and honours mode.
module des_round_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        mode,
   input  logic [63:0] data_in,
   input  logic [55:0] key_in,
   output logic [31:0] r_out,
   output logic [55:0] cd_out,
   input  logic [31:0] f_in,
   output logic [3:0]  round_idx,
   output logic        busy,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] data_out
);

   typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_l;
   logic [31:0] r_r;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [3:0]  r_round;
   logic        w_last;
   logic [1:0]  w_amt_enc;
   logic [27:0] w_c_load;
   logic [27:0] w_d_load;
   logic [27:0] w_c_step;
   logic [27:0] w_d_step;

   // DES shift schedule: one-bit rotations in rounds 1, 2, 9 and 16, two bits elsewhere.
   function automatic logic [1:0] shift_of(input logic [4:0] k);
      case (k)
         5'd1, 5'd2, 5'd9, 5'd16: shift_of = 2'd1;
         default:                 shift_of = 2'd2;
      endcase
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
      case (n)
         2'd1:    rotl28 = {x[26:0], x[27]};
         2'd2:    rotl28 = {x[25:0], x[27:26]};
         default: rotl28 = x;
      endcase
   endfunction

   assign w_last    = (r_round == 4'd15);
   assign w_amt_enc = w_last ? 2'd0 : shift_of(5'(r_round) + 5'd2);

`ifdef DES_ROUND_CTRL_DECRYPT_EN
   logic       r_mode;
   logic [1:0] w_amt_dec;

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
      case (n)
         2'd1:    rotr28 = {x[0], x[27:1]};
         2'd2:    rotr28 = {x[1:0], x[27:2]};
         default: rotr28 = x;
      endcase
   endfunction

   // Decrypt walks the schedule backwards: C0/D0 already equal C16/D16.
   assign w_amt_dec = w_last ? 2'd0 : shift_of(5'd16 - 5'(r_round));
   assign w_c_load  = mode ? key_in[55:28] : rotl28(key_in[55:28], 2'd1);
   assign w_d_load  = mode ? key_in[27:0]  : rotl28(key_in[27:0], 2'd1);
   assign w_c_step  = r_mode ? rotr28(r_c, w_amt_dec) : rotl28(r_c, w_amt_enc);
   assign w_d_step  = r_mode ? rotr28(r_d, w_amt_dec) : rotl28(r_d, w_amt_enc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_mode <= 1'b0;
      else if (r_state == ST_IDLE && in_valid)
         r_mode <= mode;
   end
`else
   logic w_unused_mode;

   assign w_unused_mode = mode;
   assign w_c_load      = rotl28(key_in[55:28], 2'd1);
   assign w_d_load      = rotl28(key_in[27:0], 2'd1);
   assign w_c_step      = rotl28(r_c, w_amt_enc);
   assign w_d_step      = rotl28(r_d, w_amt_enc);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      busy         = 1'b0;
      out_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid)
               w_state_next = ST_ROUND;
         end
         ST_ROUND: begin
            busy = 1'b1;
            if (w_last)
               w_state_next = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Registers hold in DONE and in IDLE without a request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_l     <= '0;
         r_r     <= '0;
         r_c     <= '0;
         r_d     <= '0;
         r_round <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_l     <= data_in[63:32];
                  r_r     <= data_in[31:0];
                  r_c     <= w_c_load;
                  r_d     <= w_d_load;
                  r_round <= 4'd0;
               end
            end
            ST_ROUND: begin
               r_l     <= r_r;
               r_r     <= r_l ^ f_in;
               r_c     <= w_c_step;
               r_d     <= w_d_step;
               r_round <= r_round + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign r_out     = r_r;
   assign cd_out    = {r_c, r_d};
   assign round_idx = r_round;
   assign data_out  = {r_r, r_l};

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: wraps it with a reference DES f-datapath and checks it against a round-level DES model.
module tb_des_round_ctrl;

`ifdef DES_ROUND_CTRL_DECRYPT_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
   localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
   localparam logic [63:0] CT  = 64'h85E813540F0AB405;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        mode;
   logic [63:0] data_in;
   logic [55:0] key_in;
   logic [31:0] r_out;
   logic [55:0] cd_out;
   logic [31:0] f_in;
   logic [3:0]  round_idx;
   logic        busy;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] data_out;

   int n_tests = 0;
   int n_fail  = 0;

   des_round_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .data_in(data_in), .key_in(key_in), .r_out(r_out), .cd_out(cd_out), .f_in(f_in),
      .round_idx(round_idx), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
      .data_out(data_out)
   );

   always #5 clk = ~clk;

   // ---------------- DES tables ----------------
   int ip_t[64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                    64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   int fp_t[64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30,
                    37,5,45,13,53,21,61,29, 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                    34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   int pc1_t[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int pc2_t[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   int p_t[32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9,
                   19,13,30,6,22,11,4,25};
   int sb_t[512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   // DES numbers bits from the MSB: bit k of an n-bit word is x[n-k].
   function automatic logic [63:0] ip(input logic [63:0] x);
      logic [63:0] y;
      for (int j = 0; j < 64; j++) y[63-j] = x[64-ip_t[j]];
      return y;
   endfunction

   function automatic logic [63:0] fp(input logic [63:0] x);
      logic [63:0] y;
      for (int j = 0; j < 64; j++) y[63-j] = x[64-fp_t[j]];
      return y;
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] x);
      logic [55:0] y;
      for (int j = 0; j < 56; j++) y[55-j] = x[64-pc1_t[j]];
      return y;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] x);
      logic [47:0] y;
      for (int j = 0; j < 48; j++) y[47-j] = x[56-pc2_t[j]];
      return y;
   endfunction

   function automatic logic [47:0] e_exp(input logic [31:0] r);
      logic [47:0] y;
      int src;
      for (int b = 0; b < 8; b++)
         for (int k = 0; k < 6; k++) begin
            src = ((4*b + k - 1 + 32) % 32) + 1;
            y[47-(6*b+k)] = r[32-src];
         end
      return y;
   endfunction

   function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      logic [31:0] y;
      logic [5:0]  six;
      int row, col, v;
      x = e_exp(r) ^ k;
      for (int b = 0; b < 8; b++) begin
         six = x[47-6*b -: 6];
         row = {six[5], six[0]};
         col = six[4:1];
         v   = sb_t[b*64 + row*16 + col];
         s[31-4*b -: 4] = 4'(v);
      end
      for (int j = 0; j < 32; j++) y[31-j] = s[32-p_t[j]];
      return y;
   endfunction

   // Combinational round datapath around the controller.
   always_comb f_in = des_f(r_out, pc2(cd_out));

   // ---------------- reference model ----------------
   function automatic int sh(input int i);
      return (i == 1 || i == 2 || i == 9 || i == 16) ? 1 : 2;
   endfunction

   function automatic int cum(input int n);
      int s = 0;
      for (int i = 1; i <= n; i++) s += sh(i);
      return s;
   endfunction

   function automatic logic [27:0] rl28(input logic [27:0] x, input int n);
      int m;
      m = n % 28;
      return (x << m) | (x >> (28 - m));
   endfunction

   // C/D seen during round k+1 (k = round_idx): source of K(k+1) when encrypting, K(16-k) when decrypting.
   function automatic logic [55:0] sched_cd(input logic [55:0] key, input bit dec, input int k);
      int n;
      n = dec ? cum(16 - k) : cum(k + 1);
      return {rl28(key[55:28], n), rl28(key[27:0], n)};
   endfunction

   // Returns {R_nr, L_nr} after nr Feistel rounds.
   function automatic logic [63:0] feistel(input logic [63:0] blk, input logic [55:0] key, input bit dec, input int nr);
      logic [31:0] l, r, t;
      l = blk[63:32];
      r = blk[31:0];
      for (int k = 0; k < nr; k++) begin
         t = r;
         r = l ^ des_f(r, pc2(sched_cd(key, dec, k)));
         l = t;
      end
      return {r, l};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- cycle compare process ----------------
   int          m_phase = -1;      // -1 idle, 0..15 round index, 16 output pending
   bit          m_zero  = 1'b1;    // registers still hold reset values
   logic [63:0] m_blk;
   logic [55:0] m_key;
   bit          m_dec;
   logic [63:0] m_tmp;
   int          cyc = 0;
   int          prev_acc = 0;
   bit          have_prev = 1'b0;
   bit          b2b = 1'b0;
   int          n_acc = 0;
   int          n_xfer = 0;

   always @(negedge clk) begin
      cyc++;
      if (!b2b) have_prev = 1'b0;
      if (!rst_n) begin
         chk("rst_in_ready", in_ready, 1);
         chk("rst_busy", busy, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_round_idx", round_idx, 0);
         chk("rst_r_out", r_out, 0);
         chk("rst_cd_out", cd_out, 0);
         chk("rst_data_out", data_out, 0);
         m_phase = -1;
         m_zero  = 1'b1;
      end else begin
         chk("in_ready", in_ready, m_phase == -1);
         chk("busy", busy, m_phase >= 0 && m_phase < 16);
         chk("out_valid", out_valid, m_phase == 16);
         if (m_phase >= 0 && m_phase < 16) begin
            chk("round_idx", round_idx, m_phase);
            chk("cd_out", cd_out, sched_cd(m_key, m_dec, m_phase));
            m_tmp = feistel(m_blk, m_key, m_dec, m_phase);
            chk("r_out", r_out, m_tmp[63:32]);
         end else begin
            chk("round_idx_rest", round_idx, 0);
         end
         if (m_phase == 16)
            chk("data_out", data_out, feistel(m_blk, m_key, m_dec, 16));
         if (m_phase == -1 && m_zero) begin
            chk("idle_r_out", r_out, 0);
            chk("idle_cd_out", cd_out, 0);
            chk("idle_data_out", data_out, 0);
         end
         // outcome of the coming edge
         if (m_phase == -1) begin
            if (in_valid) begin
               m_blk   = data_in;
               m_key   = key_in;
               m_dec   = DEC_EN && mode;
               m_phase = 0;
               m_zero  = 1'b0;
               n_acc++;
               if (b2b && have_prev) chk("b2b_spacing", cyc - prev_acc, 18);
               prev_acc  = cyc;
               have_prev = 1'b1;
            end
         end else if (m_phase < 16) begin
            m_phase++;
         end else if (out_ready) begin
            n_xfer++;
            $display("[TB] block %0d: dec=%0d in=%h key=%h out=%h", n_xfer, m_dec, m_blk, m_key, data_out);
            m_phase = -1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_block(input logic [63:0] blk, input logic [55:0] key, input logic md,
                            input int hold, output logic [63:0] res, output int lat);
      int g = 0;
      while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
      chk("accept_wait", in_ready, 1);
      in_valid = 1'b1; data_in = blk; key_in = key; mode = md;
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in  = {$urandom, $urandom};
      key_in   = 56'({$urandom, $urandom});
      mode     = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      repeat (hold) begin @(posedge clk); #1; end
      res = data_out;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] res, blk;
      logic [55:0] key;
      logic        md;
      int          lat, g, start, xb;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; data_in = '0; key_in = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // model pinned to published DES values
      chk("pin_ip", ip(PT), 64'hCC00CCFFF0AAF0AA);
      chk("pin_pc1", pc1(KEY), 56'hF0CCAAF556678F);
      chk("pin_k1", pc2(sched_cd(pc1(KEY), 1'b0, 0)), 48'h1B02EFFC7072);
      chk("pin_model_enc", fp(feistel(ip(PT), pc1(KEY), 1'b0, 16)), CT);
      chk("pin_model_dec", fp(feistel(ip(CT), pc1(KEY), 1'b1, 16)), PT);
      chk("pin_dec_cd0", sched_cd(pc1(KEY), 1'b1, 0), pc1(KEY));
      repeat (2) @(posedge clk);
      #1;

      run_block(ip(PT), pc1(KEY), 1'b0, 0, res, lat);
      chk("kat_enc", fp(res), CT);
      chk("kat_latency", lat, 16);

`ifdef DES_ROUND_CTRL_DECRYPT_EN
      run_block(ip(CT), pc1(KEY), 1'b1, 0, res, lat);
      chk("kat_dec", fp(res), PT);
`else
      run_block(ip(PT), pc1(KEY), 1'b1, 0, res, lat);
      chk("mode_ignored", fp(res), CT);
`endif

      // backpressure
      xb = n_xfer;
      run_block(ip(PT), pc1(KEY), 1'b0, 5, res, lat);
      chk("bp_result", fp(res), CT);
      chk("bp_one_xfer", n_xfer - xb, 1);

      // reset in the middle of round 8
      g = 0;
      in_valid = 1'b1; data_in = ip(PT); key_in = pc1(KEY); mode = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (round_idx != 4'd7 && g < 40) begin @(posedge clk); #1; g++; end
      chk("reach_round7", round_idx, 7);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_round_idx", round_idx, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_block(ip(PT), pc1(KEY), 1'b0, 0, res, lat);
      chk("post_rst_kat", fp(res), CT);

      // back-to-back, four blocks
      b2b = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      start = n_acc; g = 0;
      while (n_acc - start < 4 && g < 200) begin
         data_in = {$urandom, $urandom};
         key_in  = 56'({$urandom, $urandom});
         mode    = 1'($urandom);
         @(posedge clk); #1; g++;
      end
      in_valid = 1'b0;
      chk("b2b_count", n_acc - start, 4);
      g = 0;
      while (!in_ready && g < 40) begin @(posedge clk); #1; g++; end
      out_ready = 1'b0; b2b = 1'b0;

      // key schedule: zero key and walking ones across both halves
      blk = {$urandom, $urandom};
      run_block(blk, 56'd0, 1'b0, 0, res, lat);
      chk("zero_key", res, feistel(blk, 56'd0, 1'b0, 16));
      for (int p = 0; p < 56; p += 9) begin
         key = 56'd1 << p;
         blk = {$urandom, $urandom};
         run_block(blk, key, 1'b0, 0, res, lat);
         chk("walk_key", res, feistel(blk, key, 1'b0, 16));
      end
      key = 56'h80000008000000;
      run_block(blk, key, 1'b1, 1, res, lat);
      chk("walk_key_msb", res, feistel(blk, key, DEC_EN, 16));

      // randomized traffic
      for (int n = 0; n < 24; n++) begin
         blk = {$urandom, $urandom};
         key = 56'({$urandom, $urandom});
         md  = 1'($urandom);
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         run_block(blk, key, md, $urandom_range(0, 3), res, lat);
         chk("rand_block", res, feistel(blk, key, DEC_EN && md, 16));
      end

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
